dot_channel_seq: RTL and testbench
==================================

# dot_channel_seq

Sequencer for one `dot_channel_24` instance. It walks every (cs, phase) pair of a layer and drives `ws_load`/`dc_load` until the channel reports `valid`. It then captures the dot-product result and hands it downstream on a valid/ready port. It sits between the layer-level control FSM (start/done) and the dot channel datapath.

## Interface
- `CS_NUM`, default 9: number of cs values per phase, 1..16.
- `PHASE_NUM`, default 6: number of phases per layer, 1..8.
- `TIMEOUT`, default 31: maximum cycles in LOAD before abort, 1..255.
- Widths use `` `data_len `` from `num_data.v`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a layer; sampled only in IDLE.
- `abort`  in  1  synchronous abort, any state.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.
- `err`  out  1  sticky timeout flag; cleared by an accepted `start`.
- `ws_load`  out  1  to the dot channel.
- `dc_load`  out  1  to the dot channel.
- `cs`  out  4  current cs index.
- `phase`  out  3  current phase index.
- `dc_valid`  in  1  dot channel `valid`.
- `dc_q`  in  `` `data_len ``  dot channel `q`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts.
- `res_q`  out  `` `data_len ``  captured result.
- `res_cs`  out  4  tag: cs of the result.
- `res_phase`  out  3  tag: phase of the result.

## Operation
- States: IDLE, LOAD, OUT, DONE.
- IDLE:
  - All outputs 0.
  - `start`=1 → clear `err`, set cs=0 and phase=0, go to LOAD.
- LOAD:
  - `ws_load`=`dc_load`=1; `cs`/`phase` are stable.
  - `dc_valid`=1 → capture `dc_q`, `cs` and `phase` into `res_*`, set `res_valid`=1, go to OUT.
  - The loads are 0 in OUT, so the dot channel's inner counter and valid clear between items.
- OUT:
  - Loads are 0; `res_*` are held stable while `res_valid`=1 and `res_ready`=0.
  - On `res_valid`&`res_ready`, `res_valid` drops.
    - If cs=CS_NUM-1 and phase=PHASE_NUM-1 → go to DONE.
    - Else if cs=CS_NUM-1 → cs=0, phase+1, go to LOAD.
    - Else cs+1, go to LOAD.
  - Order is cs-fast, phase-slow.
- DONE: `done`=1 for one cycle → IDLE.
- Timeout:
  - An 8-bit counter runs in LOAD and resets on entry.
  - Reaching TIMEOUT without `dc_valid` → `err`=1, go to IDLE.
  - No `done` is issued and no `res_valid` is raised.
- Abort:
  - From any state, go to IDLE next cycle.
  - Loads and `res_valid` drop; a pending result is discarded.
  - `err` is unchanged; `done` is not pulsed.
  - `abort` has priority over every other transition, including the `dc_valid` capture and the timeout.
- `start` is ignored when not in IDLE, including the DONE cycle.

## Timing
- Asynchronous reset: state IDLE, every output 0, counters 0, `res_q` 0.
- `start` at edge k → `ws_load`/`dc_load`/`busy` high after edge k.
- `dc_valid` sampled high at edge n → after edge n: loads 0 and `res_valid` 1.
- `res_ready` high at edge m with `res_valid` set → after edge m: LOAD for the next pair, or DONE for the last one.
- Minimum loads-low gap between items is 1 cycle, reached when `res_ready` is held high.
- Item period is the dot channel latency + 1 cycle + any backpressure.
- Full layer with `res_ready` tied high: `done` appears one cycle after the last handshake.
- Loads never assert in the same cycle as `res_valid`.
- `cs`/`phase` change only on the OUT→LOAD transition.

## Structure
- Add state encodings and the tag widths (cs 4, phase 3) to a shared package/include alongside `num_data.v`.
- One natural sub-module: `seq_index_counter`.
  - Holds the cs/phase pair.
  - Inputs: clear, advance.
  - Outputs: last flag and the indices.
  - Parameterised by CS_NUM and PHASE_NUM.
- Everything else is a single FSM plus the output registers.

## Test plan
1. CS_NUM=2, PHASE_NUM=2, model channel valid 4 cycles after loads rise, `res_ready`=1 → four results tagged (0,0),(1,0),(0,1),(1,1); `done` once; `err`=0.
2. Backpressure: hold `res_ready`=0 for 5 cycles after the first result → `res_q`/tags stable, loads 0, next LOAD starts 1 cycle after ready rises.
3. TIMEOUT=10, channel never asserts valid → after 10 LOAD cycles `err`=1, IDLE, no `done`; next `start` clears `err`.
4. `abort` asserted in the same cycle as `dc_valid` → next cycle IDLE, `res_valid`=0, no capture.
5. `rst_n` dropped mid-LOAD (asynchronous, between edges) → all outputs 0 immediately; after release, `start` restarts from (0,0).
6. `start` pulsed during LOAD and during DONE → ignored; exactly one layer sequence and one `done`.

Source files
------------

// File: rtl/dot_channel_seq_pkg.sv
// Shared types and widths for the dot channel sequencer.
// DATA_LEN mirrors `data_len from num_data.v.
package dot_channel_seq_pkg;

  localparam int DATA_LEN = 16;
  localparam int CS_W     = 4;
  localparam int PHASE_W  = 3;
  localparam int TMO_W    = 8;

  typedef logic [DATA_LEN-1:0] data_t;
  typedef logic [CS_W-1:0]     cs_t;
  typedef logic [PHASE_W-1:0]  phase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/dot_channel_seq_if.sv
// Channel-side and result-side signals of the sequencer.
// The master is the sequencer, and the slave is the channel plus the downstream consumer.
interface dot_channel_seq_if;
  import dot_channel_seq_pkg::*;

  logic   ws_load;
  logic   dc_load;
  cs_t    cs;
  phase_t phase;
  logic   dc_valid;
  data_t  dc_q;
  logic   res_valid;
  logic   res_ready;
  data_t  res_q;
  cs_t    res_cs;
  phase_t res_phase;

  modport master (
    output ws_load, dc_load, cs, phase, res_valid, res_q, res_cs, res_phase,
    input  dc_valid, dc_q, res_ready
  );

  modport slave (
    input  ws_load, dc_load, cs, phase, res_valid, res_q, res_cs, res_phase,
    output dc_valid, dc_q, res_ready
  );

endinterface

// File: rtl/seq_index_counter.sv
// Holds the (cs, phase) pair and walks it cs-fast, phase-slow.
// The clear input has priority over advance.
module seq_index_counter
  import dot_channel_seq_pkg::*;
#(
  parameter int CS_NUM    = 9,
  parameter int PHASE_NUM = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   advance,
  output cs_t    cs,
  output phase_t phase,
  output logic   last
);

  cs_t    cs_reg;
  phase_t phase_reg;
  logic   cs_wrap;

  assign cs_wrap = (cs_reg == cs_t'(CS_NUM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_reg    <= '0;
      phase_reg <= '0;
    end else if (clear) begin
      cs_reg    <= '0;
      phase_reg <= '0;
    end else if (advance) begin
      if (cs_wrap) begin
        cs_reg    <= '0;
        phase_reg <= (phase_reg == phase_t'(PHASE_NUM - 1)) ? '0 : phase_reg + 1'b1;
      end else begin
        cs_reg <= cs_reg + 1'b1;
      end
    end
  end

  assign cs    = cs_reg;
  assign phase = phase_reg;
  assign last  = cs_wrap && (phase_reg == phase_t'(PHASE_NUM - 1));

endmodule

// File: rtl/dot_channel_seq.sv
// Sequencer for one dot channel: it loads each (cs, phase) pair, captures the result,
// and hands it downstream on a valid/ready port, with a timeout and an abort.
module dot_channel_seq
  import dot_channel_seq_pkg::*;
#(
  parameter int CS_NUM    = 9,
  parameter int PHASE_NUM = 6,
  parameter int TIMEOUT   = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic err,
  dot_channel_seq_if.master ch
);

  seq_state_e       state_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             load_reg;
  logic             res_valid_reg;
  logic             done_reg;
  logic             err_reg;
  data_t            res_q_reg;
  cs_t              res_cs_reg;
  phase_t           res_phase_reg;

  cs_t    idx_cs;
  phase_t idx_phase;
  logic   idx_last;
  logic   handshake;
  logic   tmo_hit;
  logic   idx_clear;
  logic   idx_advance;

  assign handshake = (state_reg == ST_OUT) && res_valid_reg && ch.res_ready;
  assign tmo_hit   = (state_reg == ST_LOAD) && !ch.dc_valid &&
                     (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));

  // The indices read 0 in IDLE, so they are cleared on every path back to it.
  assign idx_clear   = abort || (state_reg == ST_IDLE) || (state_reg == ST_DONE) || tmo_hit;
  assign idx_advance = handshake && !idx_last;

  seq_index_counter #(
    .CS_NUM    (CS_NUM),
    .PHASE_NUM (PHASE_NUM)
  ) u_index (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (idx_clear),
    .advance (idx_advance),
    .cs      (idx_cs),
    .phase   (idx_phase),
    .last    (idx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      tmo_cnt_reg   <= '0;
      load_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      res_q_reg     <= '0;
      res_cs_reg    <= '0;
      res_phase_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg     <= ST_IDLE;
        tmo_cnt_reg   <= '0;
        load_reg      <= 1'b0;
        res_valid_reg <= 1'b0;
        res_q_reg     <= '0;
        res_cs_reg    <= '0;
        res_phase_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              err_reg     <= 1'b0;
              tmo_cnt_reg <= '0;
              load_reg    <= 1'b1;
              state_reg   <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (ch.dc_valid) begin
              res_q_reg     <= ch.dc_q;
              res_cs_reg    <= idx_cs;
              res_phase_reg <= idx_phase;
              res_valid_reg <= 1'b1;
              load_reg      <= 1'b0;
              state_reg     <= ST_OUT;
            end else if (tmo_hit) begin
              err_reg       <= 1'b1;
              load_reg      <= 1'b0;
              res_q_reg     <= '0;
              res_cs_reg    <= '0;
              res_phase_reg <= '0;
              state_reg     <= ST_IDLE;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
          end
          ST_OUT: begin
            if (handshake) begin
              res_valid_reg <= 1'b0;
              if (idx_last) begin
                done_reg  <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                tmo_cnt_reg <= '0;
                load_reg    <= 1'b1;
                state_reg   <= ST_LOAD;
              end
            end
          end
          ST_DONE: begin
            res_q_reg     <= '0;
            res_cs_reg    <= '0;
            res_phase_reg <= '0;
            state_reg     <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign done         = done_reg;
  assign err          = err_reg;
  assign ch.ws_load   = load_reg;
  assign ch.dc_load   = load_reg;
  assign ch.cs        = idx_cs;
  assign ch.phase     = idx_phase;
  assign ch.res_valid = res_valid_reg;
  assign ch.res_q     = res_q_reg;
  assign ch.res_cs    = res_cs_reg;
  assign ch.res_phase = res_phase_reg;

endmodule

// File: tb/tb_dot_channel_seq.sv
// Directed bench for dot_channel_seq with a 2x2 layer, a model channel that is valid
// after 4 load cycles, and result values tagged by (cs, phase).
module tb_dot_channel_seq;
  import dot_channel_seq_pkg::*;

  localparam int CS_N = 2;
  localparam int PH_N = 2;
  localparam int TMO  = 10;
  localparam int LAT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ch_en = 1'b1;
  logic busy, done, err;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   ld_cnt   = 0;
  int   n;

  dot_channel_seq_if bus();

  dot_channel_seq #(
    .CS_NUM    (CS_N),
    .PHASE_NUM (PH_N),
    .TIMEOUT   (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .ch    (bus.master)
  );

  always #5 clk = ~clk;

  // Model channel: valid once loads have been sampled high LAT times.
  always_ff @(posedge clk) begin
    ld_cnt <= bus.dc_load ? ld_cnt + 1 : 0;
    if (done) done_cnt <= done_cnt + 1;
  end
  assign bus.dc_valid = ch_en && bus.dc_load && (ld_cnt >= LAT);
  assign bus.dc_q     = DATA_LEN'(32'hA000 + 32'(bus.cs) * 16 + 32'(bus.phase));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(output int cnt);
    cnt = 0;
    while (bus.res_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // ready held high; called at a negedge where the pair is already loading
  task automatic run_item(input int c, input int p, input logic [31:0] q,
                          input bit last, input int gap);
    int g;
    wait_res(g);
    $display("item cs=%0d phase=%0d q=%h gap=%0d", bus.res_cs, bus.res_phase, bus.res_q, g);
    chk("gap", 32'(g), 32'(gap));
    chk("res_q", 32'(bus.res_q), q);
    chk("res_cs", 32'(bus.res_cs), 32'(c));
    chk("res_phase", 32'(bus.res_phase), 32'(p));
    chk("load_in_out", 32'(bus.ws_load), 32'd0);
    @(negedge clk);
    chk("rv_drop", 32'(bus.res_valid), 32'd0);
    if (last) chk("done_pulse", 32'(done), 32'd1);
    else      chk("next_load", 32'(bus.dc_load), 32'd1);
  endtask

  initial begin
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(bus.dc_load), 32'd0);
    chk("rst_rv", 32'(bus.res_valid), 32'd0);
    chk("rst_q", 32'(bus.res_q), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // full layer, ready tied high
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ws", 32'(bus.ws_load), 32'd1);
    chk("t1_cs0", 32'({bus.cs, 1'b0, bus.phase}), 32'd0);
    run_item(0, 0, 32'hA000, 1'b0, 5);
    run_item(1, 0, 32'hA010, 1'b0, 5);
    run_item(0, 1, 32'hA001, 1'b0, 5);
    run_item(1, 1, 32'hA011, 1'b1, 5);
    @(negedge clk);
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // backpressure on the first result
    bus.res_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_res(n);
    chk("t2_gap", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_rv_hold", 32'(bus.res_valid), 32'd1);
      chk("t2_q_hold", 32'(bus.res_q), 32'hA000);
      chk("t2_tag_hold", 32'({bus.res_cs, 1'b0, bus.res_phase}), 32'd0);
      chk("t2_load_low", 32'(bus.dc_load), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t2_rv_drop", 32'(bus.res_valid), 32'd0);
    chk("t2_next_load", 32'(bus.dc_load), 32'd1);
    chk("t2_cs1", 32'(bus.cs), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t2_abort_idle", 32'(busy), 32'd0);
    chk("t2_abort_load", 32'(bus.dc_load), 32'd0);
    chk("t2_abort_q", 32'(bus.res_q), 32'd0);
    chk("t2_abort_cs", 32'(bus.cs), 32'd0);
    chk("t2_no_done", 32'(done_cnt), 32'd1);

    // timeout with a silent channel
    ch_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (bus.dc_load === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t3_load_cycles", 32'(n), 32'd10);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_rv", 32'(bus.res_valid), 32'd0);
    chk("t3_no_done", 32'(done_cnt), 32'd1);
    ch_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_err_clear", 32'(err), 32'd0);
    chk("t3_restart", 32'(bus.dc_load), 32'd1);

    // abort coincident with dc_valid
    n = 0;
    while (bus.dc_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid_lat", 32'(n), 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_rv", 32'(bus.res_valid), 32'd0);
    chk("t4_no_capture", 32'(bus.res_q), 32'd0);
    chk("t4_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("t4_rv_late", 32'(bus.res_valid), 32'd0);

    // asynchronous reset while loading the second pair
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_item(0, 0, 32'hA000, 1'b0, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_load", 32'({bus.ws_load, bus.dc_load}), 32'd0);
    chk("t5_cs", 32'(bus.cs), 32'd0);
    chk("t5_q", 32'(bus.res_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // stray starts during LOAD and DONE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_start_idx", 32'({bus.cs, 1'b0, bus.phase}), 32'd0);
    chk("t6_load", 32'(bus.dc_load), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_cs_kept", 32'(bus.cs), 32'd0);
    run_item(0, 0, 32'hA000, 1'b0, 4);
    run_item(1, 0, 32'hA010, 1'b0, 5);
    run_item(0, 1, 32'hA001, 1'b0, 5);
    run_item(1, 1, 32'hA011, 1'b1, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_done_ignored", 32'(busy), 32'd0);
    chk("t6_no_load", 32'(bus.dc_load), 32'd0);
    @(negedge clk);
    chk("t6_still_idle", 32'(busy), 32'd0);
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
